// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared constants and state encoding for the round-robin decoder arbiter.
`timescale 1ns/1ps
package decoder_rr_arbiter_pkg;
   localparam int unsigned NUM_REQ = 8;
   localparam int unsigned IDX_W = 3;
   localparam int unsigned HOLD_W = 8;
   localparam logic [1:0] DEC_ENA_ON = 2'b10;
   localparam logic [1:0] DEC_ENA_OFF = 2'b00;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GRANT = 2'd1,
      GAP = 2'd2
   } state_t;
endpackage

// File: rtl/decoder_rr_arbiter_rr_pick.sv
// Wrap-around priority search: first set request bit scanning upward from ptr+1.
`timescale 1ns/1ps
module rr_pick
   import decoder_rr_arbiter_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [IDX_W-1:0]   idx,
   output logic               found
);

   logic [IDX_W-1:0] cand;

   always_comb begin
      idx = '0;
      found = 1'b0;
      cand = '0;
      // candidate index wraps naturally in IDX_W bits; i == NUM_REQ revisits ptr last
      for (int i = 1; i <= NUM_REQ; i++) begin
         cand = ptr + IDX_W'(i);
         if (!found && req[cand]) begin
            found = 1'b1;
            idx = cand;
         end
      end
   end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter granting one of eight requesters access to a shared 3-8 decoder.
`timescale 1ns/1ps
module decoder_rr_arbiter
   import decoder_rr_arbiter_pkg::*;
#(
   parameter int unsigned MAX_HOLD = 16
) (
   input  logic               iClk,
   input  logic               iRst_n,
   input  logic [NUM_REQ-1:0] iReq,
   input  logic               iDone,
   output logic [NUM_REQ-1:0] oGrant,
   output logic [IDX_W-1:0]   oGrantIdx,
   output logic               oGrantVld,
   output logic [IDX_W-1:0]   oDecData,
   output logic [1:0]         oDecEna,
   output logic               oTimeout
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

   state_t state, state_nxt;
   logic [IDX_W-1:0] ptr, ptr_nxt;
   logic [IDX_W-1:0] cur_idx, cur_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic timeout_nxt;
   logic at_limit;
   logic [IDX_W-1:0] pick_idx;
   logic pick_found;

   logic grant_vld_nxt;
   logic [IDX_W-1:0] grant_idx_nxt;
   logic [NUM_REQ-1:0] grant_nxt;
   logic [1:0] dec_ena_nxt;

   rr_pick u_rr_pick (
      .req   (iReq),
      .ptr   (ptr),
      .idx   (pick_idx),
      .found (pick_found)
   );

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         state <= IDLE;
         ptr <= 3'd7;
         cur_idx <= '0;
         hold_cnt <= '0;
      end else begin
         state <= state_nxt;
         ptr <= ptr_nxt;
         cur_idx <= cur_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      ptr_nxt = ptr;
      cur_nxt = cur_idx;
      hold_nxt = hold_cnt;
      timeout_nxt = 1'b0;
      at_limit = (hold_cnt == HOLD_LAST);
      case (state)
         IDLE: begin
            if (pick_found) begin
               state_nxt = GRANT;
               cur_nxt = pick_idx;
               hold_nxt = '0;
            end
         end
         GRANT: begin
            if (iDone || !iReq[cur_idx] || at_limit) begin
               state_nxt = GAP;
               ptr_nxt = cur_idx;
               // a completion or withdrawal on the limit edge is a normal release
               timeout_nxt = at_limit && !iDone && iReq[cur_idx];
            end else begin
               hold_nxt = hold_cnt + 1'b1;
            end
         end
         GAP: begin
            state_nxt = IDLE;
            hold_nxt = '0;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are derived from the next state so they register on the same edge.
   always_comb begin
      grant_vld_nxt = (state_nxt == GRANT);
      grant_idx_nxt = grant_vld_nxt ? cur_nxt : '0;
      grant_nxt = grant_vld_nxt ? (NUM_REQ'(1) << cur_nxt) : '0;
      dec_ena_nxt = grant_vld_nxt ? DEC_ENA_ON : DEC_ENA_OFF;
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         oGrant <= '0;
         oGrantIdx <= '0;
         oGrantVld <= 1'b0;
         oDecData <= '0;
         oDecEna <= DEC_ENA_OFF;
         oTimeout <= 1'b0;
      end else begin
         oGrant <= grant_nxt;
         oGrantIdx <= grant_idx_nxt;
         oGrantVld <= grant_vld_nxt;
         oDecData <= grant_idx_nxt;
         oDecEna <= dec_ena_nxt;
         oTimeout <= timeout_nxt;
      end
   end

endmodule

// File: doc/decoder_rr_arbiter.md
DECODER_RR_ARBITER -- requirements
Module: decoder_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 16, is the maximum number of cycles one grant is held before forced release (legal range 2..255).
REQ-002 iClk  input  1  single system clock; all state changes on the rising edge.
REQ-003 iRst_n  input  1  reset, asynchronous, active-low.
REQ-004 iReq  input  8  request vector; bit n is requester n and is held high while it needs the shared decoder.
REQ-005 iDone  input  1  granted requester finished; sampled only in GRANT.
REQ-006 oGrant  output  8  one-hot grant, active-high; all zero when no grant.
REQ-007 oGrantIdx  output  3  binary index of the current grantee; 0 when no grant.
REQ-008 oGrantVld  output  1  high while a grant is active.
REQ-009 oDecData  output  3  select code for the shared 3-8 decoder; equals oGrantIdx.
REQ-010 oDecEna  output  2  decoder enable; 2'b10 (G1=1, G2=0) while oGrantVld=1, otherwise 2'b00.
REQ-011 oTimeout  output  1  one-cycle pulse marking a forced release at MAX_HOLD.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, GRANT, GAP.
REQ-013 IDLE: if iReq != 0, select the first set bit scanning upward from (ptr+1) mod 8 with wrap-around, register it, and enter GRANT on the same edge; if iReq == 0, stay in IDLE.
REQ-014 Grant latency SHALL be one cycle: a request sampled in IDLE at edge k makes oGrantVld=1 after edge k.
REQ-015 GRANT: oGrant, oGrantIdx, oDecData, oDecEna, oGrantVld SHALL be stable; changes on non-granted iReq bits SHALL be ignored.
REQ-016 GRANT: the hold counter SHALL start at 0 on entry and increment each cycle.
REQ-017 GRANT exits to GAP on the first edge where iDone=1, or iReq[oGrantIdx]=0, or hold counter == MAX_HOLD-1.
REQ-018 oTimeout SHALL pulse for the GAP cycle only when the exit is due to the counter and iDone=0 and iReq[oGrantIdx]=1 on that edge; a simultaneous iDone suppresses it.
REQ-019 On GRANT exit, ptr SHALL load the released index.
REQ-020 GAP: lasts exactly one cycle with all grant outputs deasserted (oDecEna=2'b00), then enters IDLE unconditionally; consecutive grants are therefore separated by at least two non-granted cycles.
REQ-021 A requester that timed out and still requests SHALL receive lower priority than every other active requester in the next arbitration.
REQ-022 All outputs SHALL be registered; no combinational path from iReq/iDone to any output.

Reset
REQ-023 While iRst_n=0: state=IDLE, ptr=7 (requester 0 first), hold counter=0, oGrant=0, oGrantIdx=0, oDecData=0, oDecEna=2'b00, oGrantVld=0, oTimeout=0, all applied immediately without a clock edge.
REQ-024 Reset asserted mid-grant SHALL drop the grant at once; after release, arbitration restarts from requester 0.

Structure
REQ-025 A shared package/header SHALL hold NUM_REQ=8, IDX_W=3, DEC_ENA_ON=2'b10, DEC_ENA_OFF=2'b00, and the state encodings IDLE/GRANT/GAP.
REQ-026 The wrap-around priority search SHALL be one combinational sub-module, rr_pick (inputs iReq, ptr; outputs index and found flag); the rest is a single FSM with counter.

Verification
REQ-027 Reset release, iReq=8'h00 for 5 cycles -> oGrantVld=0 and oDecEna=2'b00 throughout.
REQ-028 iReq=8'h81 held, iDone pulsed 3 cycles after each grant -> grants alternate 0,7,0,7; oDecData matches; oDecEna=2'b10 only during GRANT.
REQ-029 iReq=8'h24 from reset, iDone=0 -> idx 2 granted for exactly 16 cycles, oTimeout pulses once, next grant idx 5.
REQ-030 Grant to idx 3, then iReq[3] drops while iReq[6] rises -> GAP follows that edge, then idx 6 granted; oTimeout stays 0.
REQ-031 iDone=1 on the same edge as the counter reaching 15 -> single release, oTimeout=0.
REQ-032 iRst_n pulsed low mid-grant of idx 4 -> outputs zero without waiting for iClk; after release with iReq=8'h30, idx 4 granted first.
